// File: rtl/timer_seq_pkg.sv
// Shared definitions for the timer sequencer: sequencer FSM states, default
// parameter values and a pointer-width helper for the request queue.
//
// The request entry {cycles, tag} is declared as a packed struct inside
// timer_seq_fifo, where the widths are known as parameters.
package timer_seq_pkg;

  localparam int unsigned DefWidth    = 32;
  localparam int unsigned DefTagWidth = 4;
  localparam int unsigned DefDepth    = 4;
  localparam int unsigned StatsWidth  = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  // Index width for a queue of 'depth' entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/timer_seq_fifo.sv
// Request queue for timer_sequencer: DEPTH entries of {cycles, tag}.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   push_i                write push_cycles_i/push_tag_i (ignored when full)
//   pop_i                 drop the head entry (ignored when empty)
//   head_cycles_o/tag_o   current head entry, meaningful while !empty_o
//   full_o, empty_o       occupancy flags
//
// DEPTH must be a power of two; the pointers carry one extra wrap bit so that
// full and empty can be told apart when the index bits match.
module timer_seq_fifo
  import timer_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned TAG_WIDTH = DefTagWidth,
  parameter int unsigned DEPTH     = DefDepth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     push_cycles_i,
  input  logic [TAG_WIDTH-1:0] push_tag_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     head_cycles_o,
  output logic [TAG_WIDTH-1:0] head_tag_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW = ptr_width(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0]     cycles;
    logic [TAG_WIDTH-1:0] tag;
  } req_t;

  req_t            mem_q [DEPTH];
  req_t            push_req;
  req_t            head_req;
  logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   rd_ptr_q, rd_ptr_d;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign push_req = '{cycles: push_cycles_i, tag: push_tag_i};
  assign head_req = mem_q[rd_ptr_q[PtrW-1:0]];

  assign head_cycles_o = head_req.cycles;
  assign head_tag_o    = head_req.tag;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= push_req;
  end

endmodule

// File: rtl/timer_sequencer.sv
// Initiator side of the go/cycles/done timer handshake. Queues delay requests,
// issues them one at a time to an external timer and emits a tagged one-cycle
// completion event when each delay has elapsed.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (req_ready = queue not full)
//   req_cycles, req_tag      delay (0 allowed) and tag echoed on completion
//   timer_go, timer_cycles   one-cycle start pulse and count to the timer
//   timer_done               timer done (high while the timer is idle)
//   evt_valid, evt_tag       one-cycle completion pulse and its tag
//   busy                     queue non-empty or a request in flight
//   evt_count                (TIMER_SEQ_STATS_EN only) evt_valid pulse count
//
// Build option: define TIMER_SEQ_STATS_EN to add the evt_count output.
//
// Latency for a request of N>0 cycles popped in cycle t: timer_go in t+1,
// timer done in t+1+N, evt_valid in t+2+N. A zero-cycle request never reaches
// the timer (it needs cycles>0) and completes in t+1.
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned TAG_WIDTH = DefTagWidth,
  parameter int unsigned DEPTH     = DefDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WIDTH-1:0]      req_cycles,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  timer_go,
  output logic [WIDTH-1:0]      timer_cycles,
  input  logic                  timer_done,
  output logic                  evt_valid,
  output logic [TAG_WIDTH-1:0]  evt_tag,
  output logic                  busy
`ifdef TIMER_SEQ_STATS_EN
  ,
  output logic [StatsWidth-1:0] evt_count
`endif
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     cur_cycles_q, cur_cycles_d;
  logic [TAG_WIDTH-1:0] cur_tag_q, cur_tag_d;
  logic                 timer_go_q, timer_go_d;
  logic                 evt_valid_q, evt_valid_d;
  logic [TAG_WIDTH-1:0] evt_tag_q, evt_tag_d;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [WIDTH-1:0]     head_cycles;
  logic [TAG_WIDTH-1:0] head_tag;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full;

  timer_seq_fifo #(
    .WIDTH     (WIDTH),
    .TAG_WIDTH (TAG_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk_i         (clk),
    .rst_i         (rst),
    .push_i        (fifo_push),
    .push_cycles_i (req_cycles),
    .push_tag_i    (req_tag),
    .pop_i         (fifo_pop),
    .head_cycles_o (head_cycles),
    .head_tag_o    (head_tag),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cur_cycles_d = cur_cycles_q;
    cur_tag_d    = cur_tag_q;
    timer_go_d   = 1'b0;
    evt_valid_d  = 1'b0;
    evt_tag_d    = evt_tag_q;
    fifo_pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          cur_cycles_d = head_cycles;
          cur_tag_d    = head_tag;
          if (head_cycles == '0) begin
            // Zero delay completes immediately; the timer is never started.
            evt_valid_d = 1'b1;
            evt_tag_d   = head_tag;
          end else begin
            // go is registered, so it is high exactly during StIssue.
            timer_go_d = 1'b1;
            state_d    = StIssue;
          end
        end
      end
      StIssue: begin
        // The timer still reports its idle done=1 here; do not sample it.
        state_d = StWait;
      end
      StWait: begin
        if (timer_done) begin
          evt_valid_d = 1'b1;
          evt_tag_d   = cur_tag_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cur_cycles_q <= '0;
      cur_tag_q    <= '0;
      timer_go_q   <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_cycles_q <= cur_cycles_d;
      cur_tag_q    <= cur_tag_d;
      timer_go_q   <= timer_go_d;
      evt_valid_q  <= evt_valid_d;
      evt_tag_q    <= evt_tag_d;
    end
  end

  assign timer_go     = timer_go_q;
  assign timer_cycles = cur_cycles_q;
  assign evt_valid    = evt_valid_q;
  assign evt_tag      = evt_tag_q;
  assign busy         = !fifo_empty || (state_q != StIdle);

`ifdef TIMER_SEQ_STATS_EN
  logic [StatsWidth-1:0] evt_count_q, evt_count_d;

  // Counts together with the pulse, so evt_count includes the event on show.
  always_comb begin
    evt_count_d = evt_count_q;
    if (evt_valid_d) evt_count_d = evt_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) evt_count_q <= '0;
    else     evt_count_q <= evt_count_d;
  end

  assign evt_count = evt_count_q;
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
module tb_timer_sequencer;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 4;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_cycles = '0;
  logic [TW-1:0] req_tag = '0;
  logic          timer_go;
  logic [W-1:0]  timer_cycles;
  logic          timer_done;
  logic          evt_valid;
  logic [TW-1:0] evt_tag;
  logic          busy;
`ifdef TIMER_SEQ_STATS_EN
  logic [31:0]   evt_count;
`endif

  timer_sequencer #(.WIDTH(W), .TAG_WIDTH(TW), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_cycles   (req_cycles),
    .req_tag      (req_tag),
    .timer_go     (timer_go),
    .timer_cycles (timer_cycles),
    .timer_done   (timer_done),
    .evt_valid    (evt_valid),
    .evt_tag      (evt_tag),
    .busy         (busy)
`ifdef TIMER_SEQ_STATS_EN
    ,
    .evt_count    (evt_count)
`endif
  );

  always #5 clk = ~clk;

  // Responder timer: after a go of N cycles, done is low for N-1 cycles and
  // high again N cycles after the go cycle. Idle timer reports done=1.
  logic [W-1:0] tmr_rem;
  always @(posedge clk or posedge rst) begin
    if (rst)                tmr_rem <= '0;
    else if (timer_go)      tmr_rem <= timer_cycles - 1;
    else if (tmr_rem != 0)  tmr_rem <= tmr_rem - 1;
  end
  assign timer_done = (tmr_rem == 0);

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a plain request list plus absolute cycle numbers at
  // which the next go and next event are due.
  int     m_cyc_q[$];
  int     m_tag_q[$];
  longint free_at = 0;
  longint busy_until = 0;
  longint go_at = -1;
  longint evt_at = -1;
  longint go_n = 0;
  int     evt_t = 0;
  longint m_count = 0;

  // Logs consulted by the directed tests.
  longint go_log[$];
  longint evt_cyc_log[$];
  int     evt_tag_log[$];
  bit     seen_full = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_timer_go", timer_go, 0);
      chk("rst_timer_cycles", timer_cycles, 0);
      chk("rst_evt_valid", evt_valid, 0);
      chk("rst_evt_tag", evt_tag, 0);
      chk("rst_busy", busy, 0);
      m_cyc_q.delete();
      m_tag_q.delete();
      free_at = 0;
      busy_until = 0;
      go_at = -1;
      evt_at = -1;
      m_count = 0;
`ifdef TIMER_SEQ_STATS_EN
      chk("rst_evt_count", evt_count, 0);
`endif
    end else begin
      bit exp_ready;
      bit exp_go;
      bit exp_evt;
      bit exp_busy;
      exp_ready = (m_cyc_q.size() < D);
      exp_go    = (cyc == go_at);
      exp_evt   = (cyc == evt_at);
      exp_busy  = (m_cyc_q.size() > 0) || (cyc < busy_until);
      if (exp_evt) m_count++;

      chk("req_ready", req_ready, exp_ready);
      chk("timer_go", timer_go, exp_go);
      chk("evt_valid", evt_valid, exp_evt);
      chk("busy", busy, exp_busy);
      if (exp_go)  chk("timer_cycles", timer_cycles, go_n);
      if (exp_evt) chk("evt_tag", evt_tag, evt_t);
`ifdef TIMER_SEQ_STATS_EN
      chk("evt_count", evt_count, m_count);
`endif

      if (timer_go) go_log.push_back(cyc);
      if (evt_valid) begin
        evt_cyc_log.push_back(cyc);
        evt_tag_log.push_back(int'(evt_tag));
      end
      if (!req_ready) seen_full = 1;

      // This cycle's pop (idle sequencer, non-empty list) and push.
      if (cyc >= free_at && m_cyc_q.size() > 0) begin
        int n;
        int t;
        n = m_cyc_q.pop_front();
        t = m_tag_q.pop_front();
        if (n == 0) begin
          evt_at  = cyc + 1;
          evt_t   = t;
          free_at = cyc + 1;
        end else begin
          go_at      = cyc + 1;
          go_n       = n;
          evt_at     = cyc + 2 + n;
          evt_t      = t;
          free_at    = cyc + 2 + n;
          busy_until = cyc + 2 + n;
        end
      end
      if (req_valid && exp_ready) begin
        m_cyc_q.push_back(int'(req_cycles));
        m_tag_q.push_back(int'(req_tag));
      end
    end
  end

  task automatic clear_logs();
    go_log.delete();
    evt_cyc_log.delete();
    evt_tag_log.delete();
    seen_full = 0;
  endtask

  // Called just after a posedge; returns just after the posedge that accepts.
  task automatic push(input int n, input int tag, output longint acc);
    int k;
    k = 0;
    req_valid  = 1'b1;
    req_cycles = W'(n);
    req_tag    = TW'(tag);
    @(negedge clk);
    while (!req_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) chk("push_timeout", 0, 1);
    acc = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    repeat (3) @(negedge clk);
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("drain_timeout", busy, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint p;
    longint p0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: cycles=5 tag=3; pop one cycle after acceptance.
    clear_logs();
    push(5, 3, p);
    drain();
    chk("t1_go_count", go_log.size(), 1);
    chk("t1_evt_count", evt_cyc_log.size(), 1);
    if (go_log.size() == 1) chk("t1_go_cycle", go_log[0], p + 2);
    if (evt_cyc_log.size() == 1) begin
      chk("t1_evt_cycle", evt_cyc_log[0], p + 8);
      chk("t1_evt_tag", evt_tag_log[0], 3);
    end

    // 2: cycles=1 -> event 3 cycles after pop, single pulse.
    clear_logs();
    push(1, 5, p);
    drain();
    chk("t2_evt_count", evt_cyc_log.size(), 1);
    if (evt_cyc_log.size() == 1) chk("t2_evt_cycle", evt_cyc_log[0], p + 4);

    // 3: cycles=0 tag=9 -> event the cycle after pop, no go.
    clear_logs();
    push(0, 9, p);
    drain();
    chk("t3_go_count", go_log.size(), 0);
    chk("t3_evt_count", evt_cyc_log.size(), 1);
    if (evt_cyc_log.size() == 1) begin
      chk("t3_evt_cycle", evt_cyc_log[0], p + 2);
      chk("t3_evt_tag", evt_tag_log[0], 9);
    end

    // 4: five requests while the first is in flight; queue fills, order kept.
    clear_logs();
    push(8, 1, p);
    push(2, 2, p);
    push(0, 3, p);
    push(3, 4, p);
    push(1, 5, p);
    drain();
    chk("t4_seen_full", seen_full, 1);
    chk("t4_evt_count", evt_tag_log.size(), 5);
    for (int i = 0; i < 5 && i < evt_tag_log.size(); i++)
      chk($sformatf("t4_evt_tag%0d", i), evt_tag_log[i], i + 1);

`ifdef TIMER_SEQ_STATS_EN
    // 6: three requests advance evt_count by three.
    @(negedge clk);
    p0 = longint'(evt_count);
    @(posedge clk);
    #1;
    push(2, 1, p);
    push(0, 2, p);
    push(4, 3, p);
    drain();
    chk("t6_evt_count_delta", longint'(evt_count) - p0, 3);
`else
    p0 = 0;
`endif

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 900; i++) begin
      req_valid  = ($urandom_range(0, 99) < 40);
      req_cycles = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 12));
      req_tag    = TW'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    drain();

    // 5: reset during WAIT of a 100-cycle request drops it silently.
    clear_logs();
    push(100, 6, p);
    repeat (20) @(posedge clk);
    #1;
    chk("t5_in_wait_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_evt_valid", evt_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    repeat (130) @(posedge clk);
    #1;
    chk("t5_no_evt_after_rst", evt_cyc_log.size(), 0);
    chk("t5_no_go_after_rst", go_log.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
